flt_add_arbiter: RTL and testbench

- Shares one combinational half-precision `float_adder` instance between two requesters.
  - Adder interface: num1, num2, result[15:0], overflow, zero, nan.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; operands and results are registered around the adder, so the adder is off the timing path of the requesters.
- Sits between the two compute clients and the shared adder in the FP datapath.

---
 rtl/flt_pkg.sv | 32 +++
 rtl/float_adder.sv | 65 ++++++
 rtl/flt_add_arbiter_rr_arb2.sv | 38 +++
 rtl/flt_add_arbiter.sv | 151 +++++++++++++++
 tb/tb_flt_add_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/flt_pkg.sv
// Shared FP16 datapath definitions: field widths, arbiter state encoding, payload structs.
package flt_pkg;

  localparam int unsigned FP16_W = 16;
  localparam int unsigned EXP_W  = 5;
  localparam int unsigned FRA_W  = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_RESP = ST_RESP
  } arb_state_e;

  typedef logic req_id_t;

  typedef struct packed {
    logic [FP16_W-1:0] a;
    logic [FP16_W-1:0] b;
  } fp_pair_t;

  typedef struct packed {
    logic [FP16_W-1:0] result;
    logic              overflow;
    logic              zero;
    logic              nan;
  } fp_rsp_t;

endpackage

// File: rtl/float_adder.sv
// Combinational FP16 adder: exact alignment, truncating normalisation, subnormal support.
// exp=31 on either input reports nan; a result exponent of 31 or more reports overflow.
module float_adder
  import flt_pkg::*;
(
  input  logic [FP16_W-1:0] num1,
  input  logic [FP16_W-1:0] num2,
  output logic [FP16_W-1:0] result,
  output logic              overflow,
  output logic              zero,
  output logic              nan
);

  // 11-bit significand, 31 alignment bits (max exponent gap 30), 1 carry bit
  localparam int unsigned SUM_W = 43;

  logic [FP16_W-1:0] big, sml;
  logic [EXP_W-1:0]  e_big, e_sml, diff;
  logic [FRA_W:0]    m_big, m_sml;
  logic [SUM_W-1:0]  al_big, al_sml, sum;
  logic [5:0]        lead;
  logic signed [7:0] e_r;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    zero     = 1'b0;
    nan      = 1'b0;
    if (num1[14:0] >= num2[14:0]) begin
      big = num1;
      sml = num2;
    end else begin
      big = num2;
      sml = num1;
    end
    e_big  = (big[14:10] == '0) ? 5'd1 : big[14:10];
    e_sml  = (sml[14:10] == '0) ? 5'd1 : sml[14:10];
    m_big  = {|big[14:10], big[9:0]};
    m_sml  = {|sml[14:10], sml[9:0]};
    diff   = e_big - e_sml;
    al_big = {1'b0, m_big, 31'b0};
    al_sml = {1'b0, m_sml, 31'b0} >> diff;
    sum    = (big[15] == sml[15]) ? (al_big + al_sml) : (al_big - al_sml);
    lead   = '0;
    for (int i = 0; i < int'(SUM_W); i++) begin
      if (sum[i]) lead = 6'(i);
    end
    e_r = $signed({3'b0, e_big}) + $signed({2'b0, lead}) - 8'sd41;

    if (num1[14:10] == 5'h1f || num2[14:10] == 5'h1f) begin
      nan    = 1'b1;
      result = 16'h7e00;
    end else if (sum == '0) begin
      zero = 1'b1;
    end else if (e_r >= 8'sd31) begin
      overflow = 1'b1;
      result   = {big[15], 5'h1f, 10'h000};
    end else if (e_r <= 8'sd0) begin
      result = {big[15], 5'h00, 10'(sum >> (6'd32 - {1'b0, e_big}))};
    end else begin
      result = {big[15], 5'(e_r), 10'(sum >> (lead - 6'd10))};
    end
  end

endmodule

// File: rtl/flt_add_arbiter_rr_arb2.sv
// Two-input round-robin grant; pointer moves past the owner when its operation completes.
module rr_arb2
  import flt_pkg::*;
#(
  parameter req_id_t FIRST_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  logic       done_i,
  input  req_id_t    done_id_i,
  output logic [1:0] gnt_c_o
);

  req_id_t ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= FIRST_PRIO;
    end else if (done_i) begin
      ptr_q <= ~done_id_i;
    end
  end

  always_comb begin
    gnt_c_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_c_o = 2'b01;
        2'b10:   gnt_c_o = 2'b10;
        2'b11:   gnt_c_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_c_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/flt_add_arbiter.sv
// Shares one float_adder between two requesters: IDLE -> CALC -> RESP, registered around the adder.
// Define FLT_ARB_STATS_EN to add saturating per-requester op and exception counters.
module flt_add_arbiter
  import flt_pkg::*;
#(
  parameter int unsigned FIRST_PRIO = 0
`ifdef FLT_ARB_STATS_EN
  , parameter int unsigned STAT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [FP16_W-1:0] req_a0,
  input  logic [FP16_W-1:0] req_b0,
  input  logic [FP16_W-1:0] req_a1,
  input  logic [FP16_W-1:0] req_b1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [FP16_W-1:0] rsp_result,
  output logic              rsp_overflow,
  output logic              rsp_zero,
  output logic              rsp_nan,
  output logic              busy
`ifdef FLT_ARB_STATS_EN
  , input  logic              stat_clr
  , output logic [STAT_W-1:0] stat_ops0
  , output logic [STAT_W-1:0] stat_ops1
  , output logic [STAT_W-1:0] stat_exc
`endif
);

  arb_state_e        state_q;
  fp_pair_t          op_q;
  fp_rsp_t           rsp_q;
  req_id_t           owner_q;
  logic [1:0]        rsp_valid_q;
  logic              busy_q;
  logic              arm_q;

  logic [1:0]        gnt_c;
  logic              accept_c;
  logic              done_c;
  fp_pair_t          pick_c;
  logic [FP16_W-1:0] add_res_c;
  logic              add_ovf_c, add_zero_c, add_nan_c;

  // arm_q keeps req_ready low while in reset and for the first cycle after release
  rr_arb2 #(.FIRST_PRIO(1'(FIRST_PRIO))) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_valid),
    .en_i      (arm_q && (state_q == S_IDLE)),
    .done_i    (done_c),
    .done_id_i (owner_q),
    .gnt_c_o   (gnt_c)
  );

  float_adder u_add (
    .num1     (op_q.a),
    .num2     (op_q.b),
    .result   (add_res_c),
    .overflow (add_ovf_c),
    .zero     (add_zero_c),
    .nan      (add_nan_c)
  );

  assign req_ready = gnt_c;
  assign accept_c  = |(req_valid & gnt_c);
  assign done_c    = (state_q == S_RESP) && rsp_ready[owner_q];
  assign pick_c    = gnt_c[1] ? {req_a1, req_b1} : {req_a0, req_b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      rsp_q       <= '0;
      owner_q     <= 1'b0;
      rsp_valid_q <= 2'b00;
      busy_q      <= 1'b0;
      arm_q       <= 1'b0;
    end else begin
      arm_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            op_q    <= pick_c;
            owner_q <= req_id_t'(gnt_c[1]);
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          rsp_q       <= {add_res_c, add_ovf_c, add_zero_c, add_nan_c};
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (done_c) begin
            rsp_valid_q <= 2'b00;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_q.result;
  assign rsp_overflow = rsp_q.overflow;
  assign rsp_zero     = rsp_q.zero;
  assign rsp_nan      = rsp_q.nan;
  assign busy         = busy_q;

`ifdef FLT_ARB_STATS_EN
  logic [STAT_W-1:0] ops0_q, ops1_q, exc_q;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  // clear takes precedence over a same-cycle completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops0_q <= '0;
      ops1_q <= '0;
      exc_q  <= '0;
    end else if (stat_clr) begin
      ops0_q <= '0;
      ops1_q <= '0;
      exc_q  <= '0;
    end else if (done_c) begin
      if (owner_q) ops1_q <= sat_inc(ops1_q);
      else         ops0_q <= sat_inc(ops0_q);
      if (rsp_q.overflow || rsp_q.nan) exc_q <= sat_inc(exc_q);
    end
  end

  assign stat_ops0 = ops0_q;
  assign stat_ops1 = ops1_q;
  assign stat_exc  = exc_q;
`endif

endmodule

// File: tb/tb_flt_add_arbiter.sv
// Scoreboard bench for flt_add_arbiter: expectations queued on accept, checked on response handshake.
module tb_flt_add_arbiter;

  typedef struct packed {
    logic        care;
    logic        id;
    logic [15:0] res;
    logic [2:0]  flg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [15:0] a0, b0, a1, b1, rsp_result;
  logic        rsp_overflow, rsp_zero, rsp_nan, busy;
`ifdef FLT_ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_ops0, stat_ops1, stat_exc;
`endif

  exp_t exp0, exp1;
  exp_t sb_q[$];
  int   acc_log[$];
  int   n_cmp = 0;
  int   n_err = 0;

  flt_add_arbiter #(.FIRST_PRIO(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a0       (a0),
    .req_b0       (b0),
    .req_a1       (a1),
    .req_b1       (b1),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_zero     (rsp_zero),
    .rsp_nan      (rsp_nan),
    .busy         (busy)
`ifdef FLT_ARB_STATS_EN
    , .stat_clr   (stat_clr)
    , .stat_ops0  (stat_ops0)
    , .stat_ops1  (stat_ops1)
    , .stat_exc   (stat_exc)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // accept side pushes, response side pops
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        acc_log.push_back(i);
        sb_q.push_back((i == 0) ? exp0 : exp1);
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (rsp_valid[i] && rsp_ready[i]) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_id", 32'(i), 32'(e.id));
          if (e.care) chk("rsp_result", 32'(rsp_result), 32'(e.res));
          chk("rsp_flags", 32'({rsp_overflow, rsp_zero, rsp_nan}), 32'(e.flg));
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_op(input int id, input logic [15:0] a, input logic [15:0] b,
                        input logic care, input logic [15:0] res, input logic [2:0] flg);
    if (id == 0) begin
      a0 = a; b0 = b; exp0 = {care, 1'b0, res, flg};
    end else begin
      a1 = a; b1 = b; exp1 = {care, 1'b1, res, flg};
    end
  endtask

  task automatic wait_acc(input int id);
    bit got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      if (req_valid[id] && req_ready[id]) got = 1'b1;
    end
    chk($sformatf("accept_timeout_%0d", id), 32'(got), 32'd1);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      step();
      if (!busy) ok = 1'b1;
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b,
                       input logic care, input logic [15:0] res, input logic [2:0] flg);
    @(posedge clk);
    #1 set_op(id, a, b, care, res, flg);
    req_valid[id] = 1'b1;
    wait_acc(id);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stale;
    rst_n     = 1'b0;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
`ifdef FLT_ARB_STATS_EN
    stat_clr  = 1'b0;
`endif
    set_op(0, 16'hc0b0, 16'h1cc0, 1'b1, 16'hc0ad, 3'b000);
    set_op(1, 16'h00b8, 16'h0080, 1'b1, 16'h0138, 3'b000);

    // outputs during reset with both requesters pending
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(rsp_result), 32'd0);
    chk("rst_flags", 32'({rsp_overflow, rsp_zero, rsp_nan}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // contention from reset: grants alternate starting at requester 0
    for (int k = 0; k < 40 && acc_log.size() < 3; k++) step();
    chk("cont_accepts", 32'(acc_log.size() >= 3), 32'd1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    for (int i = 0; i < 3; i++)
      chk($sformatf("cont_grant_%0d", i), 32'((i < acc_log.size()) ? acc_log[i] : 99), 32'(i % 2));
    wait_idle();

    // single requester: same-cycle ready, response two cycles after accept
    @(posedge clk);
    #1 set_op(0, 16'h54a5, 16'h1cc0, 1'b1, 16'h54a5, 3'b000);
    req_valid = 2'b01;
    step();
    chk("single_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    step();
    chk("single_calc_vld", 32'(rsp_valid), 32'd0);
    chk("single_calc_busy", 32'(busy), 32'd1);
    step();
    chk("single_rsp_vld", 32'(rsp_valid), 32'd1);
    wait_idle();

    // backpressure on requester 0 while requester 1 waits and pulses its rsp_ready
    @(posedge clk);
    #1 rsp_ready = 2'b00;
    set_op(0, 16'h54a5, 16'h1cc0, 1'b1, 16'h54a5, 3'b000);
    req_valid = 2'b01;
    wait_acc(0);
    set_op(1, 16'h3c00, 16'h3c00, 1'b1, 16'h4000, 3'b000);
    req_valid[1] = 1'b1;
    step();
    step();
    chk("bp_rsp_vld", 32'(rsp_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1 rsp_ready = (k % 2 == 0) ? 2'b10 : 2'b00;
      step();
      chk("bp_hold_vld", 32'(rsp_valid), 32'd1);
      chk("bp_hold_res", 32'(rsp_result), 32'h54a5);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 2'b11;
    wait_acc(1);
    wait_idle();

    // flag pass-through
    issue(0, 16'he49d, 16'h649d, 1'b1, 16'h0000, 3'b010);
    issue(0, 16'h7bff, 16'h7bff, 1'b0, 16'h0000, 3'b100);
    issue(0, 16'h7c00, 16'h48e3, 1'b0, 16'h0000, 3'b001);

    // asynchronous reset during CALC; pointer had moved to requester 1
    @(posedge clk);
    #1 set_op(0, 16'h54a5, 16'h1cc0, 1'b1, 16'h54a5, 3'b000);
    req_valid = 2'b01;
    wait_acc(0);
    chk("mid_calc_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    req_valid = 2'b11;
    set_op(1, 16'h3c00, 16'h3c00, 1'b1, 16'h4000, 3'b000);
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_result", 32'(rsp_result), 32'd0);
    chk("mid_rst_flags", 32'({rsp_overflow, rsp_zero, rsp_nan}), 32'd0);
    sb_q.delete();
    acc_log.delete();
    step();
    step();
    rst_n = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 10 && acc_log.size() == 0; k++) begin
      step();
      if (rsp_valid != 2'b00) stale = 1'b1;
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    chk("post_rst_stale_vld", 32'(stale), 32'd0);
    chk("post_rst_first_grant", 32'((acc_log.size() > 0) ? acc_log[0] : 99), 32'd0);
    wait_idle();

`ifdef FLT_ARB_STATS_EN
    @(posedge clk);
    #1 stat_clr = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    issue(0, 16'h3c00, 16'h3c00, 1'b1, 16'h4000, 3'b000);
    issue(0, 16'h7bff, 16'h7bff, 1'b0, 16'h0000, 3'b100);
    issue(0, 16'h54a5, 16'h1cc0, 1'b1, 16'h54a5, 3'b000);
    issue(1, 16'h3c00, 16'h3c00, 1'b1, 16'h4000, 3'b000);
    issue(1, 16'h54a5, 16'h1cc0, 1'b1, 16'h54a5, 3'b000);
    chk("stat_ops0", 32'(stat_ops0), 32'd3);
    chk("stat_ops1", 32'(stat_ops1), 32'd2);
    chk("stat_exc", 32'(stat_exc), 32'd1);
    @(posedge clk);
    #1 stat_clr = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    step();
    chk("stat_clr_ops0", 32'(stat_ops0), 32'd0);
    chk("stat_clr_ops1", 32'(stat_ops1), 32'd0);
    chk("stat_clr_exc", 32'(stat_exc), 32'd0);
`endif

    step();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
